dds_tuning_loader: RTL and testbench

- Consumer end of the rotary front-end's `Address`/`FreqChng` interface.
- Accepts each frequency index plus its change strobe and converts the index into a DDS tuning word with a sequential shift-add multiply.
- Commits the new word phase-coherently, at an accumulator wrap.
- Runs the phase accumulator that drives the waveform LUT address.

---
 rtl/dds_pkg.sv | 27 ++
 rtl/dds_seq_mult.sv | 50 +++++
 rtl/dds_tuning_loader.sv | 144 ++++++++++++++
 tb/tb_dds_tuning_loader.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
// Shared widths, default tuning constants and FSM encoding for the DDS tuning loader.
package dds_pkg;

  localparam int ACC_W   = 32;
  localparam int PHASE_W = 12;
  localparam int IDX_W   = 11;
  localparam int IDX_MAX = 1799;

  localparam logic [ACC_W-1:0] BASE_TW_DEF = 32'd179;
  localparam logic [ACC_W-1:0] STEP_TW_DEF = 32'd179;

  // Largest tuning word below half the sample rate.
  localparam logic [ACC_W-1:0] NYQ_TW = {1'b0, {(ACC_W-1){1'b1}}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_MUL    = 2'd1,
    S_WAIT   = 2'd2,
    S_COMMIT = 2'd3
  } dds_state_e;

  // Indices above the table end are pinned to the last legal entry.
  function automatic logic [IDX_W-1:0] clamp_idx(input logic [IDX_W-1:0] a);
    return (a > IDX_W'(IDX_MAX)) ? IDX_W'(IDX_MAX) : a;
  endfunction

endpackage

// File: rtl/dds_seq_mult.sv
// Shift-add multiplier: IDX_W x ACC_W, fixed IDX_W-cycle latency after start.
module dds_seq_mult
  import dds_pkg::*;
(
  input  logic             Fg_CLK,
  input  logic             RESETn,
  input  logic             start,
  input  logic [IDX_W-1:0] multiplier,
  input  logic [ACC_W-1:0] multiplicand,
  output logic [ACC_W:0]   product,
  output logic             done
);

  localparam int CNT_W = $clog2(IDX_W + 1);

  logic [IDX_W-1:0] mplier;
  logic [ACC_W:0]   mcand;
  logic [ACC_W:0]   prod;
  logic [CNT_W-1:0] cnt;

  // Load operands on start, then one partial product per cycle; done marks the last step.
  always_ff @(posedge Fg_CLK or negedge RESETn) begin
    if (!RESETn) begin
      mplier <= '0;
      mcand  <= '0;
      prod   <= '0;
      cnt    <= '0;
      done   <= 1'b0;
    end else if (start) begin
      mplier <= multiplier;
      mcand  <= {1'b0, multiplicand};
      prod   <= '0;
      cnt    <= CNT_W'(IDX_W);
      done   <= 1'b0;
    end else if (cnt != '0) begin
      if (mplier[0]) begin
        prod <= prod + mcand;
      end
      mplier <= mplier >> 1;
      mcand  <= mcand << 1;
      cnt    <= cnt - CNT_W'(1);
      done   <= (cnt == CNT_W'(1));
    end else begin
      done <= 1'b0;
    end
  end

  assign product = prod;

endmodule

// File: rtl/dds_tuning_loader.sv
// Converts frequency indices to DDS tuning words and commits them at an accumulator wrap.
//
// state    | meaning
// S_IDLE   | no job; accepts a strobe or the pending index
// S_MUL    | multiplier running on the captured index
// S_WAIT   | result ready, waiting for an accumulator wrap
// S_COMMIT | load result into TuneWord, pulse FreqLoaded
module dds_tuning_loader
  import dds_pkg::*;
#(
  parameter logic [ACC_W-1:0] BASE_TW   = BASE_TW_DEF,
  parameter logic [ACC_W-1:0] STEP_TW   = STEP_TW_DEF,
  parameter bit               SYNC_LOAD = 1'b1
) (
  input  logic               Fg_CLK,
  input  logic               RESETn,
  input  logic [IDX_W-1:0]   Address,
  input  logic               FreqChng,
  input  logic               Enable,
  output logic [PHASE_W-1:0] PhaseOut,
  output logic [ACC_W-1:0]   TuneWord,
  output logic               Busy,
  output logic               FreqLoaded
);

  dds_state_e       state, state_nxt;
  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   acc_sum;
  logic             wrap;
  logic             commit_go;
  logic             pend_valid;
  logic [IDX_W-1:0] pend_idx;
  logic             take;
  logic [IDX_W-1:0] take_idx;
  logic [ACC_W:0]   mult_prod;
  logic             mult_done;
  logic [ACC_W+1:0] tw_sum;
  logic [ACC_W-1:0] tw_sat;
  logic [ACC_W-1:0] result_q;

  assign acc_sum   = {1'b0, acc} + {1'b0, TuneWord};
  assign wrap      = Enable & acc_sum[ACC_W];
  // With the accumulator held at zero no wrap will ever come, so commit straight away.
  assign commit_go = wrap | ~Enable;

  // The oldest waiting index (pending) is served before a coincident new strobe.
  assign take     = (state == S_IDLE) && (FreqChng || pend_valid);
  assign take_idx = pend_valid ? pend_idx : clamp_idx(Address);

  assign tw_sum = {2'b00, BASE_TW} + {1'b0, mult_prod};
  assign tw_sat = (tw_sum > {2'b00, NYQ_TW}) ? NYQ_TW : tw_sum[ACC_W-1:0];

  dds_seq_mult u_mult (
    .Fg_CLK       (Fg_CLK),
    .RESETn       (RESETn),
    .start        (take),
    .multiplier   (take_idx),
    .multiplicand (STEP_TW),
    .product      (mult_prod),
    .done         (mult_done)
  );

  // Phase accumulator, cleared and held while disabled.
  always_ff @(posedge Fg_CLK or negedge RESETn) begin
    if (!RESETn) begin
      acc <= '0;
    end else if (!Enable) begin
      acc <= '0;
    end else begin
      acc <= acc_sum[ACC_W-1:0];
    end
  end

  // One-deep pending index; the most recent strobe seen while busy wins.
  always_ff @(posedge Fg_CLK or negedge RESETn) begin
    if (!RESETn) begin
      pend_valid <= 1'b0;
      pend_idx   <= '0;
    end else if (FreqChng && !(state == S_IDLE && !pend_valid)) begin
      pend_valid <= 1'b1;
      pend_idx   <= clamp_idx(Address);
    end else if (take) begin
      pend_valid <= 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge Fg_CLK or negedge RESETn) begin
    if (!RESETn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; the wait state is skipped when the commit condition already holds.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (take) begin
          state_nxt = S_MUL;
        end
      end
      S_MUL: begin
        if (mult_done) begin
          state_nxt = (!SYNC_LOAD || commit_go) ? S_COMMIT : S_WAIT;
        end
      end
      S_WAIT: begin
        if (commit_go) begin
          state_nxt = S_COMMIT;
        end
      end
      S_COMMIT: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Result capture at multiply completion, then the committed tuning word and its strobe.
  always_ff @(posedge Fg_CLK or negedge RESETn) begin
    if (!RESETn) begin
      result_q   <= BASE_TW;
      TuneWord   <= BASE_TW;
      FreqLoaded <= 1'b0;
    end else begin
      if (state == S_MUL && mult_done) begin
        result_q <= tw_sat;
      end
      if (state == S_COMMIT) begin
        TuneWord <= result_q;
      end
      FreqLoaded <= (state == S_COMMIT);
    end
  end

  assign Busy     = (state != S_IDLE);
  assign PhaseOut = acc[ACC_W-1 -: PHASE_W];

endmodule

// File: tb/tb_dds_tuning_loader.sv
// Self-checking bench: three loader variants against a behavioural model plus directed vectors.
module tb_dds_tuning_loader;

  localparam longint TWO32 = 64'h1_0000_0000;
  localparam longint NYQ   = 64'h7FFF_FFFF;

  logic        Fg_CLK;
  logic        RESETn;
  logic [10:0] Address;
  logic        FreqChng;
  logic        Enable;

  logic [11:0] phase_o [3];
  logic [31:0] tw_o    [3];
  logic        busy_o  [3];
  logic        fl_o    [3];

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  dds_tuning_loader #(.SYNC_LOAD(1'b0)) u0 (
    .Fg_CLK(Fg_CLK), .RESETn(RESETn), .Address(Address), .FreqChng(FreqChng),
    .Enable(Enable), .PhaseOut(phase_o[0]), .TuneWord(tw_o[0]), .Busy(busy_o[0]),
    .FreqLoaded(fl_o[0]));

  dds_tuning_loader #(.BASE_TW(32'h0F00_0000), .STEP_TW(32'h0010_0000), .SYNC_LOAD(1'b1)) u1 (
    .Fg_CLK(Fg_CLK), .RESETn(RESETn), .Address(Address), .FreqChng(FreqChng),
    .Enable(Enable), .PhaseOut(phase_o[1]), .TuneWord(tw_o[1]), .Busy(busy_o[1]),
    .FreqLoaded(fl_o[1]));

  dds_tuning_loader #(.BASE_TW(32'h8000_0000), .SYNC_LOAD(1'b0)) u2 (
    .Fg_CLK(Fg_CLK), .RESETn(RESETn), .Address(Address), .FreqChng(FreqChng),
    .Enable(Enable), .PhaseOut(phase_o[2]), .TuneWord(tw_o[2]), .Busy(busy_o[2]),
    .FreqLoaded(fl_o[2]));

  initial Fg_CLK = 1'b0;
  always #5 Fg_CLK = ~Fg_CLK;

  function automatic longint p_base(int d);
    case (d)
      1:       return 64'h0F00_0000;
      2:       return 64'h8000_0000;
      default: return 179;
    endcase
  endfunction

  function automatic longint p_step(int d);
    return (d == 1) ? 64'h0010_0000 : 179;
  endfunction

  function automatic bit p_sync(int d);
    return (d == 1);
  endfunction

  function automatic int clampi(int a);
    return (a > 1799) ? 1799 : a;
  endfunction

  // Tuning word for an index: base plus index steps, limited to just under Nyquist.
  function automatic longint tw_for(int d, int idx);
    longint r;
    r = p_base(d) + longint'(clampi(idx)) * p_step(d);
    return (r > NYQ) ? NYQ : r;
  endfunction

  // Behavioural model: a job is captured, takes 11 edges to multiply, then is
  // committed on the next edge once a wrap (or disable, or unsynchronised mode) allows.
  longint m_acc [3];
  longint m_tw  [3];
  longint m_res [3];
  bit     m_job [3];
  bit     m_cnext [3];
  int     m_age [3];
  bit     m_pv  [3];
  int     m_pidx [3];
  bit     m_fl  [3];

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_acc[d] = 0; m_tw[d] = p_base(d); m_res[d] = 0; m_job[d] = 0;
      m_cnext[d] = 0; m_age[d] = 0; m_pv[d] = 0; m_pidx[d] = 0; m_fl[d] = 0;
    end
  endtask

  task automatic start_job(int d, int idx);
    m_job[d] = 1; m_age[d] = 0; m_cnext[d] = 0; m_res[d] = tw_for(d, idx);
  endtask

  task automatic model_edge();
    for (int d = 0; d < 3; d++) begin
      bit wrap, idle;
      wrap = Enable && ((m_acc[d] + m_tw[d]) >= TWO32);
      idle = !m_job[d];
      m_acc[d] = Enable ? ((m_acc[d] + m_tw[d]) % TWO32) : 0;
      m_fl[d] = 0;
      if (m_job[d]) begin
        if (m_cnext[d]) begin
          m_tw[d] = m_res[d]; m_fl[d] = 1; m_job[d] = 0; m_cnext[d] = 0;
        end else if (m_age[d] < 11) begin
          m_age[d]++;
        end else if (!p_sync(d) || !Enable || wrap) begin
          m_cnext[d] = 1;
        end
      end
      if (idle) begin
        if (m_pv[d]) begin
          start_job(d, m_pidx[d]);
          m_pv[d] = FreqChng;
          if (FreqChng) m_pidx[d] = clampi(int'(Address));
        end else if (FreqChng) begin
          start_job(d, int'(Address));
        end
      end else if (FreqChng) begin
        m_pv[d] = 1; m_pidx[d] = clampi(int'(Address));
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge Fg_CLK or negedge RESETn);
      if (!RESETn) model_reset();
      else model_edge();
    end
  end

  task automatic check(input string nm, input int d, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s dut%0d got=%0h exp=%0h t=%0t", nm, d, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every variant against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge Fg_CLK);
      if (chk_en) begin
        for (int d = 0; d < 3; d++) begin
          check("m_phase", d, longint'(phase_o[d]), m_acc[d] >> 20);
          check("m_tune",  d, longint'(tw_o[d]), m_tw[d]);
          check("m_busy",  d, longint'(busy_o[d]), longint'(m_job[d]));
          check("m_load",  d, longint'(fl_o[d]), longint'(m_fl[d]));
        end
      end
    end
  end

  task automatic tick();
    @(posedge Fg_CLK);
    #2;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy_o[0] || busy_o[1] || busy_o[2]) && n < 100) begin
      tick();
      n++;
    end
    if (busy_o[0] || busy_o[1] || busy_o[2]) check("idle_timeout", 0, 1, 0);
  endtask

  // Strobe one index, return edges from the sampling edge to FreqLoaded on dut d.
  task automatic strobe_and_measure(input int d, input int addr, output int lat);
    bit got;
    Address = 11'(addr);
    FreqChng = 1'b1;
    tick();
    FreqChng = 1'b0;
    check("busy_rise", d, longint'(busy_o[d]), 1);
    got = 0;
    lat = -1;
    for (int k = 1; k <= 200 && !got; k++) begin
      tick();
      if (fl_o[d]) begin
        got = 1;
        lat = k;
      end
    end
    if (!got) check("load_timeout", d, 0, 1);
  endtask

  typedef struct {
    int     addr;
    int     dut;
    longint exp_tw;
    int     exp_lat;
  } vec_t;

  vec_t vecs [8];
  int   lat;
  longint commits [$];

  initial begin
    vecs[0] = '{addr: 9,    dut: 0, exp_tw: 1790,        exp_lat: 13};
    vecs[1] = '{addr: 2047, dut: 0, exp_tw: 322200,      exp_lat: 13};
    vecs[2] = '{addr: 0,    dut: 0, exp_tw: 179,         exp_lat: 13};
    vecs[3] = '{addr: 1000, dut: 0, exp_tw: 179179,      exp_lat: 13};
    vecs[4] = '{addr: 1799, dut: 0, exp_tw: 322200,      exp_lat: 13};
    vecs[5] = '{addr: 2047, dut: 2, exp_tw: 64'h7FFFFFFF, exp_lat: 13};
    vecs[6] = '{addr: 0,    dut: 2, exp_tw: 64'h7FFFFFFF, exp_lat: 13};
    vecs[7] = '{addr: 0,    dut: 1, exp_tw: 64'h0F000000, exp_lat: -1};

    RESETn = 1'b0; Enable = 1'b0; FreqChng = 1'b0; Address = '0;
    repeat (3) tick();
    check("rst_tune",  0, longint'(tw_o[0]), 179);
    check("rst_phase", 0, longint'(phase_o[0]), 0);
    check("rst_busy",  0, longint'(busy_o[0]), 0);
    check("rst_load",  0, longint'(fl_o[0]), 0);
    check("rst_tune",  2, longint'(tw_o[2]), 64'h8000_0000);
    chk_en = 1;
    RESETn = 1'b1;
    Enable = 1'b1;
    repeat (20) tick();

    for (int i = 0; i < 8; i++) begin
      wait_idle();
      strobe_and_measure(vecs[i].dut, vecs[i].addr, lat);
      check("vec_tune", vecs[i].dut, longint'(tw_o[vecs[i].dut]), vecs[i].exp_tw);
      if (vecs[i].exp_lat >= 0) check("vec_latency", vecs[i].dut, lat, vecs[i].exp_lat);
      else check("vec_min_latency", vecs[i].dut, longint'(lat >= 13), 1);
      tick();
      check("load_one_cycle", vecs[i].dut, longint'(fl_o[vecs[i].dut]), 0);
    end

    // Synchronous variant with the accumulator stopped commits without waiting for a wrap.
    wait_idle();
    Enable = 1'b0;
    tick();
    strobe_and_measure(1, 4, lat);
    check("dis_latency", 1, lat, 13);
    check("dis_tune", 1, longint'(tw_o[1]), 64'h0F40_0000);
    Enable = 1'b1;

    // Strobes while busy: 5 is overwritten by 7, so only 3 and 7 are committed.
    wait_idle();
    commits.delete();
    for (int k = 0; k < 60; k++) begin
      FreqChng = (k == 0 || k == 2 || k == 6);
      Address  = (k == 0) ? 11'd3 : (k == 2) ? 11'd5 : 11'd7;
      tick();
      FreqChng = 1'b0;
      if (fl_o[0]) commits.push_back(longint'(tw_o[0]));
    end
    check("pend_count", 0, commits.size(), 2);
    if (commits.size() >= 2) begin
      check("pend_first",  0, commits[0], 716);
      check("pend_second", 0, commits[1], 1432);
    end

    // Randomised traffic with occasional mid-operation reset.
    for (int k = 0; k < 2500; k++) begin
      Enable   = ($urandom % 16) != 0;
      FreqChng = ($urandom % 6) == 0;
      Address  = 11'($urandom % 2048);
      RESETn   = ($urandom % 300) != 0;
      tick();
    end
    RESETn = 1'b1;
    FreqChng = 1'b0;
    repeat (40) tick();

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
